// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the random interval timer: FSM state encoding and LFSR constants.
package reaction_timer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR that advances every cycle; an optional mix word is XORed into
// the next state when mix_en_i is high, with a zero result replaced by 1.
module lfsr_galois #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             mix_en_i,
    input  logic [WIDTH-1:0] mix_i,
    output logic [WIDTH-1:0] lfsr_o
);

    // A zero seed would lock the register at zero forever.
    localparam logic [WIDTH-1:0] RESET_VALUE = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] lfsr_d;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        step   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        lfsr_d = step;
        if (mix_en_i) begin
            lfsr_d = step ^ mix_i;
            if (lfsr_d == '0) begin
                lfsr_d = WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= RESET_VALUE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/random_interval_timer.sv
// Timer that counts down a pseudo-random interval D = MIN_DELAY + LFSR low bits after start_i.
// Build macro RANDOM_INTERVAL_TIMER_SEED_MIX_EN mixes a free-running cycle count into the LFSR on start.
module random_interval_timer
    import reaction_timer_pkg::*;
#(
    parameter int          WIDTH      = 30,
    parameter int          RANGE_BITS = 24,
    parameter int          MIN_DELAY  = 0,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] delay_o,
    output logic [WIDTH-1:0] remaining_o
);

    localparam longint unsigned MAX_DELAY =
        longint'(MIN_DELAY) + (64'd1 << RANGE_BITS) - 64'd1;

    if (RANGE_BITS < 1 || RANGE_BITS > 32 || RANGE_BITS > WIDTH) begin : g_bad_range_bits
        $error("RANGE_BITS must lie in 1..min(WIDTH,32)");
    end
    if (MIN_DELAY < 0 || (WIDTH < 64 && (MAX_DELAY >> WIDTH) != 64'd0)) begin : g_bad_delay
        $error("MIN_DELAY + 2**RANGE_BITS - 1 does not fit in WIDTH bits");
    end

    state_t              state_q;
    logic [WIDTH-1:0]    count_q;
    logic [WIDTH-1:0]    delay_q;
    logic                done_q;
    logic [LFSR_W-1:0]   lfsr;
    logic [WIDTH-1:0]    delay_next;
    logic                start_accept;
    logic                mix_en;
    logic [LFSR_W-1:0]   mix;

    assign start_accept = (state_q == IDLE) && start_i;
    assign delay_next   = WIDTH'(MIN_DELAY) + WIDTH'(lfsr[RANGE_BITS-1:0]);

`ifdef RANDOM_INTERVAL_TIMER_SEED_MIX_EN
    logic [LFSR_W-1:0] cycle_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + LFSR_W'(1);
        end
    end

    assign mix_en = start_accept;
    assign mix    = cycle_q;
`else
    assign mix_en = 1'b0;
    assign mix    = '0;
`endif

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .mix_en_i (mix_en),
        .mix_i    (mix),
        .lfsr_o   (lfsr)
    );

    // Abort wins over expiry; start_i is only looked at in IDLE, which includes the done cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            delay_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        delay_q <= delay_next;
                        count_q <= delay_next;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort_i) begin
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (count_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_q - WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q == COUNT);
    assign done_o      = done_q;
    assign delay_o     = delay_q;
    assign remaining_o = count_q;

    lfsr_never_zero: assert property (@(posedge clk_i) disable iff (reset_i) lfsr != '0);

endmodule

// File: doc/random_interval_timer.md
RANDOM_INTERVAL_TIMER -- requirements
Module: random_interval_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 30: bit width of delay_o, remaining_o and the internal down-counter.
REQ-002 SHALL have parameter RANGE_BITS, default 24: number of LFSR low bits used as the random offset; constrained to 1..min(WIDTH,32).
REQ-003 SHALL have parameter MIN_DELAY, default 0: fixed offset added to the random part, in cycles; MIN_DELAY + 2^RANGE_BITS - 1 SHALL fit in WIDTH bits (elaboration-time assertion).
REQ-004 SHALL have parameter SEED, default 32'h1: LFSR reset value; a value of 0 SHALL be replaced by 1.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start_i, input, 1 bit: request a new random interval; honoured only in IDLE.
REQ-008 SHALL have port abort_i, input, 1 bit: cancel the running interval.
REQ-009 SHALL have port busy_o, output, 1 bit: high while state is COUNT.
REQ-010 SHALL have port done_o, output, 1 bit: registered single-cycle pulse when an interval expires.
REQ-011 SHALL have port delay_o, output, WIDTH bits: delay value D captured at the last accepted start; holds until the next accepted start.
REQ-012 SHALL have port remaining_o, output, WIDTH bits: current down-counter value.

Function
REQ-013 SHALL contain a 32-bit right-shifting Galois LFSR that advances every cycle: next = (lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 0).
REQ-014 SHALL make the LFSR never reach zero; a zero state is unreachable from a nonzero seed, and there is no lock-up recovery path.
REQ-015 SHALL implement FSM states IDLE and COUNT; transitions: IDLE->COUNT on start_i; COUNT->IDLE on abort_i or expiry.
REQ-016 SHALL, on start_i in IDLE, compute D = MIN_DELAY + lfsr_reg[RANGE_BITS-1:0] (unsigned, WIDTH bits) from the current-cycle LFSR value, and load D into both delay_o and the counter.
REQ-017 SHALL, in COUNT with counter != 0, decrement the counter by 1 per cycle.
REQ-018 SHALL, in COUNT with counter == 0: next edge done_o=1, state IDLE, counter stays 0.
REQ-019 SHALL produce latency as follows: with start_i sampled at edge k, done_o is high during the cycle after edge k+D+1; D=0 gives done_o one cycle after COUNT is entered.
REQ-020 SHALL give abort_i in COUNT priority over expiry: next state IDLE, no done_o, counter cleared to 0, delay_o retained.
REQ-021 SHALL ignore abort_i in IDLE and ignore start_i in COUNT, including the expiry cycle.
REQ-022 SHALL accept start_i during the cycle done_o is high, because the FSM is already in IDLE; back-to-back intervals are therefore separated by exactly one IDLE cycle.
REQ-023 SHALL keep done_o low in every cycle other than the one following expiry.

Reset
REQ-024 SHALL, on reset_i sampled high, set state=IDLE, lfsr=SEED (or 1), counter=0, delay_o=0, remaining_o=0, busy_o=0, done_o=0.
REQ-025 SHALL let reset_i during COUNT cancel the interval with no done_o, and SHALL make reset override start_i and abort_i.

Configuration
REQ-026 SHALL support the macro RANDOM_INTERVAL_TIMER_SEED_MIX_EN; when defined, an accepted start_i XORs a free-running 32-bit cycle counter into the LFSR next state (zero result forced to 1), so user timing adds entropy.
REQ-027 SHALL, without RANDOM_INTERVAL_TIMER_SEED_MIX_EN, omit the cycle counter entirely, making the sequence fully deterministic from SEED; all timing in REQ-015..REQ-025 is identical in both builds.

Structure
REQ-028 SHALL take from the shared package reaction_timer_pkg the FSM state enum (IDLE, COUNT), LFSR_TAPS = 32'h80200003 and LFSR_W = 32.
REQ-029 SHALL place the LFSR in one sub-module, lfsr_galois (params WIDTH, TAPS, SEED; ports clk_i, reset_i, mix_en_i, mix_i, lfsr_o).

Verification (SEED=1, RANGE_BITS=4, MIN_DELAY=3, WIDTH=8, macro undefined)
REQ-030 SHALL cover: start_i in first cycle after reset -> delay_o=4 (lfsr=1), busy_o high 5 cycles, done_o pulse once, remaining_o counts 4,3,2,1,0.
REQ-031 SHALL cover: start_i in second cycle after reset (lfsr=32'h80200003) -> delay_o=6, done_o high 7 cycles after the start edge.
REQ-032 SHALL cover: start_i held high continuously -> start accepted on done_o cycles, with exactly one IDLE cycle between intervals; start_i during COUNT causes no reload.
REQ-033 SHALL cover: abort_i asserted when remaining_o=2 -> IDLE next cycle, no done_o, remaining_o=0, delay_o unchanged; abort_i and expiry in the same cycle -> no done_o.
REQ-034 SHALL cover: reset_i pulsed mid-COUNT -> all outputs 0 next cycle, no done_o; the next start reproduces delay_o=4.
REQ-035 SHALL cover, with the macro defined: two runs with differing idle gaps before start yield different delay_o values, never lfsr=0; a 10^6-cycle run with the constraint check asserts D always within [3,18].
